display_arbiter: RTL and testbench

Arbitrates ownership of the four-digit seven-segment display between two requesters and drives the `segment0..segment3` digit inputs of the display multiplexer. Requester 0 (system/debug) has priority over requester 1 (application). A minimum hold time keeps a newly displayed value from flickering. When neither requester owns the display, a fixed idle value is shown.

---
 rtl/display_arbiter.sv | 110 +++++++++++
 tb/tb_display_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// Two-requester ownership arbiter for the four-digit seven-segment display.
// Requester 0 has priority; a minimum hold time stops a new owner's value from flickering.
module display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 56000,
  parameter logic [15:0] IDLE_VALUE  = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [15:0] value0,
  input  logic        req1,
  input  logic [15:0] value1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic [3:0]  segment0,
  output logic [3:0]  segment1,
  output logic [3:0]  segment2,
  output logic [3:0]  segment3
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  localparam logic [31:0] HoldLoad = 32'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        busy_q, busy_d;
  logic [15:0] seg_q, seg_d;
  logic        hold_expired;

  always_comb begin
    state_d      = state_q;
    hold_expired = (hold_q == '0);

    unique case (state_q)
      StIdle: begin
        if (req0) begin
          state_d = StOwn0;
        end else if (req1) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        // Requester 1 can only take over once requester 0 lets go.
        if (hold_expired && !req0) begin
          state_d = req1 ? StOwn1 : StIdle;
        end
      end
      StOwn1: begin
        if (hold_expired) begin
          if (req0) begin
            state_d = StOwn0;
          end else if (!req1) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Every entry into an owned state restarts the hold window.
    if (state_d != state_q && state_d != StIdle) begin
      hold_d = HoldLoad;
    end else if (!hold_expired) begin
      hold_d = hold_q - 32'd1;
    end else begin
      hold_d = hold_q;
    end

    unique case (state_d)
      StOwn0:  seg_d = value0;
      StOwn1:  seg_d = value1;
      default: seg_d = IDLE_VALUE;
    endcase

    gnt0_d = (state_d == StOwn0);
    gnt1_d = (state_d == StOwn1);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      hold_q  <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
      seg_q   <= IDLE_VALUE;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      busy_q  <= busy_d;
      seg_q   <= seg_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign busy     = busy_q;
  assign segment0 = seg_q[3:0];
  assign segment1 = seg_q[7:4];
  assign segment2 = seg_q[11:8];
  assign segment3 = seg_q[15:12];

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter with HOLD_CYCLES=4: cycle vectors with hand-derived expectations,
// plus handover and starvation sequences.
module tb_display_arbiter;

  typedef struct {
    logic        rst;
    logic        r0;
    logic        r1;
    logic [15:0] v0;
    logic [15:0] v1;
    logic        g0;
    logic        g1;
    logic [15:0] seg;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [15:0] value0, value1;
  logic        gnt0, gnt1, busy;
  logic [3:0]  segment0, segment1, segment2, segment3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  vec_t sb[$];

  always #5 clk = ~clk;

  display_arbiter #(
    .HOLD_CYCLES(4),
    .IDLE_VALUE (16'h0000)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req0    (req0),
    .value0  (value0),
    .req1    (req1),
    .value1  (value1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .busy    (busy),
    .segment0(segment0),
    .segment1(segment1),
    .segment2(segment2),
    .segment3(segment3)
  );

  function automatic vec_t mk(input logic rst, input logic r0, input logic r1,
                              input logic [15:0] v0, input logic [15:0] v1,
                              input logic g0, input logic g1, input logic [15:0] seg);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.v0 = v0; v.v1 = v1;
    v.g0 = g0; v.g1 = g1; v.seg = seg;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, then compare the outputs after the edge against the queued record.
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    reset  = v.rst;
    req0   = v.r0;
    req1   = v.r1;
    value0 = v.v0;
    value1 = v.v1;
    sb.push_back(v);
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard cycle %0d: got empty queue expected 1 entry", cyc);
    end else begin
      e = sb.pop_front();
      check("gnt0", 16'(gnt0), 16'(e.g0));
      check("gnt1", 16'(gnt1), 16'(e.g1));
      check("busy", 16'(busy), 16'(e.g0 | e.g1));
      check("segments", {segment3, segment2, segment1, segment0}, e.seg);
    end
  endtask

  vec_t vecs[26];

  initial begin
    reset  = 1'b1;
    req0   = 1'b0;
    req1   = 1'b0;
    value0 = '0;
    value1 = '0;

    //            rst r0 r1 value0    value1    g0 g1 segments
    vecs[0]  = mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000);
    // Single requester 1; request drops while the hold runs, value still tracked.
    vecs[1]  = mk(0, 0, 1, 16'h0000, 16'h4321, 0, 1, 16'h4321);
    vecs[2]  = mk(0, 0, 0, 16'h0000, 16'h4321, 0, 1, 16'h4321);
    vecs[3]  = mk(0, 0, 0, 16'h0000, 16'h0005, 0, 1, 16'h0005);
    vecs[4]  = mk(0, 0, 0, 16'h0000, 16'h0005, 0, 1, 16'h0005);
    vecs[5]  = mk(0, 0, 0, 16'h0000, 16'h0005, 0, 0, 16'h0000);
    vecs[6]  = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000);
    // Simultaneous rise: requester 0 wins.
    vecs[7]  = mk(0, 1, 1, 16'h9999, 16'h1111, 1, 0, 16'h9999);
    vecs[8]  = mk(0, 0, 0, 16'h9999, 16'h1111, 1, 0, 16'h9999);
    vecs[9]  = mk(0, 0, 0, 16'h9990, 16'h1111, 1, 0, 16'h9990);
    vecs[10] = mk(0, 0, 0, 16'h9990, 16'h1111, 1, 0, 16'h9990);
    vecs[11] = mk(0, 0, 0, 16'h9990, 16'h1111, 0, 0, 16'h0000);
    // Preemption of requester 1 only at grant edge + 4.
    vecs[12] = mk(0, 0, 1, 16'h0000, 16'h2222, 0, 1, 16'h2222);
    vecs[13] = mk(0, 1, 1, 16'h7777, 16'h2222, 0, 1, 16'h2222);
    vecs[14] = mk(0, 1, 1, 16'h7777, 16'h2222, 0, 1, 16'h2222);
    vecs[15] = mk(0, 1, 1, 16'h7777, 16'h2223, 0, 1, 16'h2223);
    vecs[16] = mk(0, 1, 1, 16'h7777, 16'h2223, 1, 0, 16'h7777);
    vecs[17] = mk(0, 1, 1, 16'h7778, 16'h2223, 1, 0, 16'h7778);
    vecs[18] = mk(0, 1, 1, 16'h7778, 16'h2223, 1, 0, 16'h7778);
    vecs[19] = mk(0, 1, 1, 16'h7778, 16'h2223, 1, 0, 16'h7778);
    vecs[20] = mk(0, 1, 1, 16'h7778, 16'h2223, 1, 0, 16'h7778);
    vecs[21] = mk(0, 0, 1, 16'h7778, 16'h2223, 0, 1, 16'h2223);
    // Reset while owned by requester 1.
    vecs[22] = mk(1, 0, 1, 16'h0000, 16'h1234, 0, 0, 16'h0000);
    vecs[23] = mk(0, 0, 1, 16'h0000, 16'h1234, 0, 1, 16'h1234);
    vecs[24] = mk(0, 0, 0, 16'h0000, 16'h1234, 0, 1, 16'h1234);
    vecs[25] = mk(1, 0, 0, 16'h0000, 16'h1234, 0, 0, 16'h0000);

    for (int i = 0; i < 26; i++) begin
      step(vecs[i]);
    end

    // Handover: requester 0 owns for 10 cycles, then drops with requester 1 waiting.
    for (int i = 0; i < 10; i++) begin
      step(mk(0, 1, 1, 16'(16'h0100 + i), 16'h5555, 1, 0, 16'(16'h0100 + i)));
    end
    step(mk(0, 0, 1, 16'h0100, 16'h5555, 0, 1, 16'h5555));
    for (int i = 0; i < 3; i++) begin
      step(mk(0, 0, 1, 16'h0100, 16'h5555, 0, 1, 16'h5555));
    end

    // Starvation: with both requesting, requester 0 takes over and never lets go.
    for (int i = 0; i < 100; i++) begin
      step(mk(0, 1, 1, 16'h0808, 16'h5555, 1, 0, 16'h0808));
    end
    step(mk(0, 0, 0, 16'h0808, 16'h5555, 0, 0, 16'h0000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
